div_error_accumulator: RTL

DIV_ERROR_ACCUMULATOR -- requirements
Module: div_error_accumulator

---
 rtl/div_error_accumulator.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/div_error_accumulator.sv
// Measures the error of an approximate divider against an exact one over 2^LOG2_SAMPLES
// sample pairs: sum of squared quotient errors, mean, peak error and mismatch counts.
module div_error_accumulator #(
    parameter int LOG2_SAMPLES = 8,
    parameter int W            = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [W-1:0]          q_exact,
    input  logic [W-1:0]          q_approx,
    input  logic [W-1:0]          r_exact,
    input  logic [W-1:0]          r_approx,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           sse,
    output logic [31:0]           mse,
    output logic [W-1:0]          max_err,
    output logic [LOG2_SAMPLES:0] q_mismatch,
    output logic [LOG2_SAMPLES:0] r_mismatch
);

    localparam int CW = LOG2_SAMPLES + 1;
    localparam int SW = 2 * W + 2;
    localparam logic [CW-1:0] LAST = CW'((1 << LOG2_SAMPLES) - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           s1_valid_q, s1_valid_d;
    logic [W:0]     s1_diff_q, s1_diff_d;
    logic           s1_qmis_q, s1_qmis_d;
    logic           s1_rmis_q, s1_rmis_d;

    logic           s2_valid_q, s2_valid_d;
    logic [31:0]    s2_sq_q, s2_sq_d;
    logic [W-1:0]   s2_abs_q, s2_abs_d;
    logic           s2_qmis_q, s2_qmis_d;
    logic           s2_rmis_q, s2_rmis_d;

    logic [31:0]    sse_q, sse_d;
    logic [W-1:0]   max_q, max_d;
    logic [CW-1:0]  qm_q, qm_d;
    logic [CW-1:0]  rm_q, rm_d;

    logic           accept;
    logic           start_run;
    logic [W:0]     abs_full;
    logic [SW-1:0]  sq_full;
    logic [32:0]    sum;

    assign accept    = in_valid && (state_q == RUN);
    assign start_run = start && ((state_q == IDLE) || (state_q == DONE));

    // Next-state logic
    always_comb begin
        // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (accept && (cnt_q == LAST)) state_d = DRAIN;
            DRAIN:   if (!s1_valid_q && !s2_valid_q) state_d = DONE;
            DONE:    if (start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // Counter and pipeline datapath
    always_comb begin
        cnt_d      = cnt_q;
        s1_valid_d = accept;
        s1_diff_d  = s1_diff_q;
        s1_qmis_d  = s1_qmis_q;
        s1_rmis_d  = s1_rmis_q;
        s2_valid_d = s1_valid_q;
        s2_sq_d    = s2_sq_q;
        s2_abs_d   = s2_abs_q;
        s2_qmis_d  = s2_qmis_q;
        s2_rmis_d  = s2_rmis_q;
        sse_d      = sse_q;
        max_d      = max_q;
        qm_d       = qm_q;
        rm_d       = rm_q;

        // |d| always fits W bits because both quotients are unsigned W-bit values.
        abs_full = s1_diff_q[W] ? (~s1_diff_q + 1'b1) : s1_diff_q;
        sq_full  = SW'(abs_full) * SW'(abs_full);
        sum      = {1'b0, sse_q} + {1'b0, s2_sq_q};

        if (start_run) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (accept) begin
            s1_diff_d = {1'b0, q_exact} - {1'b0, q_approx};
            s1_qmis_d = (q_exact != q_approx);
            s1_rmis_d = (r_exact != r_approx);
        end

        if (s1_valid_q) begin
            s2_sq_d   = 32'(sq_full);
            s2_abs_d  = abs_full[W-1:0];
            s2_qmis_d = s1_qmis_q;
            s2_rmis_d = s1_rmis_q;
        end

        if (start_run) begin
            sse_d = '0;
            max_d = '0;
            qm_d  = '0;
            rm_d  = '0;
        end else if (s2_valid_q) begin
            sse_d = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
            if (s2_abs_q > max_q) max_d = s2_abs_q;
            qm_d = qm_q + CW'(s2_qmis_q);
            rm_d = rm_q + CW'(s2_rmis_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_diff_q  <= '0;
            s1_qmis_q  <= 1'b0;
            s1_rmis_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_sq_q    <= '0;
            s2_abs_q   <= '0;
            s2_qmis_q  <= 1'b0;
            s2_rmis_q  <= 1'b0;
            sse_q      <= '0;
            max_q      <= '0;
            qm_q       <= '0;
            rm_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            s1_valid_q <= s1_valid_d;
            s1_diff_q  <= s1_diff_d;
            s1_qmis_q  <= s1_qmis_d;
            s1_rmis_q  <= s1_rmis_d;
            s2_valid_q <= s2_valid_d;
            s2_sq_q    <= s2_sq_d;
            s2_abs_q   <= s2_abs_d;
            s2_qmis_q  <= s2_qmis_d;
            s2_rmis_q  <= s2_rmis_d;
            sse_q      <= sse_d;
            max_q      <= max_d;
            qm_q       <= qm_d;
            rm_q       <= rm_d;
        end
    end

    // Outputs decode only registered state, so in_valid never reaches in_ready.
    always_comb begin
        in_ready   = (state_q == RUN);
        busy       = (state_q == RUN) || (state_q == DRAIN);
        done       = (state_q == DONE);
        sse        = sse_q;
        mse        = sse_q >> LOG2_SAMPLES;
        max_err    = max_q;
        q_mismatch = qm_q;
        r_mismatch = rm_q;
    end

endmodule
